uart_rx_packet: RTL and testbench
=================================

// Module: uart_rx_packet
// PURPOSE
//  Host-side UART receiver for the fan telemetry link. Deserialises 8N1 bytes from rx and
//  reassembles the 3-byte packet {temp, rpm[7:0], rpm[15:8]} sent once per second.
//  Presents the last complete packet with a one-cycle strobe. Used in loopback/bench
//  boards and in any FPGA that consumes the fan controller's telemetry.
// PARAMETERS
//  UART_BPS      115200        line baud rate
//  CLK_FREQ      50_000_000    sys_clk frequency, Hz
//  TIMEOUT_CLKS  8680          max idle clocks between bytes of one packet (~2 byte times)
// PORTS
//  sys_clk    in   1   system clock; single clock domain
//  sys_rst    in   1   asynchronous, active-high reset
//  rx         in   1   serial line, idle high, asynchronous to sys_clk
//  temp_data  out  8   temperature byte of last good packet
//  rpm        out  16  fan speed of last good packet
//  pkt_valid  out  1   one-cycle strobe: temp_data/rpm just updated
//  frame_err  out  1   one-cycle strobe: stop bit sampled low
// BEHAVIOUR
//  - Reset: temp_data=0, rpm=0, pkt_valid=0, frame_err=0, synchroniser flops=1, FSM=IDLE,
//    byte index=0. Reset mid-byte or mid-packet discards all partial data.
//  - BAUD_CNT_MAX = CLK_FREQ/UART_BPS (integer, 434 at defaults); counter width $clog2 of it.
//  - rx passes a 2-flop synchroniser; start is detected on a synchronised 1->0 transition.
//  - Byte FSM: IDLE -> START on falling edge; START: count to BAUD_CNT_MAX/2-1, sample;
//    line high = false start -> IDLE, low -> DATA. DATA: 8 samples, each BAUD_CNT_MAX
//    clocks apart (mid-bit), LSB first into shift reg. STOP: sample after BAUD_CNT_MAX clocks;
//    high -> byte good, low -> frame_err pulses for 1 cycle, byte dropped, byte index -> 0.
//    STOP -> IDLE right after the sample (new falling edge accepted from the next cycle).
//  - Packet assembly: byte0 -> temp buffer, byte1 -> rpm[7:0] buffer, byte2 -> rpm[15:8].
//    On byte2 good: temp_data/rpm load from buffers and pkt_valid=1 on the same edge,
//    one sys_clk after the stop-bit sample; byte index -> 0.
//  - Outputs change only on a complete good packet; partial packets never leak.
//  - Inter-byte timeout: idle counter runs in IDLE while byte index != 0; reaching
//    TIMEOUT_CLKS forces byte index -> 0 (resync). Counter clears on each start detect.
//  - Timeout expiring on the same cycle as a start detect: start wins, index resets,
//    incoming byte is treated as byte0.
//  - frame_err and pkt_valid never assert together.
// STRUCTURE
//  - Package uart_pkg: BAUD_CNT_MAX function, PKT_BYTES=3, byte-index constants,
//    byte FSM state encodings (IDLE/START/DATA/STOP).
//  - Sub-module uart_rx_byte: synchroniser + byte FSM; outputs byte[7:0], byte_vld, frame_err.
//  - Top: byte index counter, temp/rpm buffers, timeout counter, output registers.
// TESTING
//  1 Send 0x1E,0x34,0x12 at 115200, 1 stop -> pkt_valid once; temp_data=0x1E, rpm=0x1234.
//  2 Byte2 stop bit forced low -> frame_err 1 cycle, no pkt_valid, outputs keep old values;
//    next clean packet 0x20,0xE8,0x03 -> temp_data=0x20, rpm=0x03E8.
//  3 Send 0x55, idle 9000 clocks, then 0x28,0x10,0x27 -> rpm=0x2710, temp=0x28 (resync).
//  4 200-clock low glitch on rx in IDLE -> false start, no strobes, FSM back to IDLE.
//  5 Assert sys_rst during byte1 data bits -> all outputs 0 immediately; post-reset packet
//    0x19,0xB8,0x0B -> temp_data=0x19, rpm=0x0BB8.
//  6 Back-to-back packets with zero idle, baud ±2% skew -> both decoded, two pkt_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the fan-telemetry UART receiver.
//   baud_cnt_max() : sys_clk cycles per UART bit (integer division)
//   PKT_BYTES      : bytes per telemetry packet {temp, rpm[7:0], rpm[15:8]}
//   IDX_*          : byte-index values within a packet
//   rx_state_e     : byte-level receive FSM states
package uart_pkg;

  localparam int unsigned PKT_BYTES = 3;

  localparam logic [1:0] IDX_TEMP   = 2'd0;
  localparam logic [1:0] IDX_RPM_LO = 2'd1;
  localparam logic [1:0] IDX_RPM_HI = 2'(PKT_BYTES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                               input int unsigned bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, start-edge detect and mid-bit sampling FSM.
//   clk_i       : system clock
//   rst_i       : asynchronous active-high reset
//   rx_i        : raw serial line, idle high
//   byte_o      : last received byte (valid while byte_vld_o is high)
//   byte_vld_o  : one-cycle strobe, stop bit sampled high
//   frame_err_o : one-cycle strobe, stop bit sampled low (byte dropped)
//   start_o     : start edge accepted this cycle (combinational)
//   idle_o      : FSM is waiting for a start edge
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned UART_BPS = 115200
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       frame_err_o,
  output logic       start_o,
  output logic       idle_o
);

  localparam int unsigned BaudMax = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int unsigned CntW    = $clog2(BaudMax);
  localparam logic [CntW-1:0] CntFull = CntW'(BaudMax - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(BaudMax / 2 - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic            sync1_q, sync2_q, prev_q;
  rx_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            byte_vld_q, frame_err_q;

  assign start_o     = (state_q == StIdle) && prev_q && !sync2_q;
  assign idle_o      = (state_q == StIdle);
  assign byte_o      = shift_q;
  assign byte_vld_o  = byte_vld_q;
  assign frame_err_o = frame_err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= rx_i;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_o) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          // Re-check the line at mid start bit; a high line was only a glitch.
          if (cnt_q == CntHalf) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync2_q ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StData: begin
          if (cnt_q == CntFull) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};  // LSB arrives first
            if (bit_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        StStop: begin
          if (cnt_q == CntFull) begin
            cnt_q   <= '0;
            state_q <= StIdle;
            if (sync2_q) begin
              byte_vld_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CntOne;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_packet.sv
// Fan telemetry receiver: reassembles {temp, rpm[7:0], rpm[15:8]} from 8N1 bytes.
//   sys_clk   : system clock
//   sys_rst   : asynchronous active-high reset
//   rx        : serial line, idle high, asynchronous to sys_clk
//   temp_data : temperature byte of the last good packet
//   rpm       : fan speed of the last good packet
//   pkt_valid : one-cycle strobe, temp_data/rpm just updated
//   frame_err : one-cycle strobe, a stop bit was sampled low
module uart_rx_packet
  import uart_pkg::*;
#(
  parameter int unsigned UART_BPS     = 115200,
  parameter int unsigned CLK_FREQ     = 50_000_000,
  parameter int unsigned TIMEOUT_CLKS = 8680
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rx,
  output logic [7:0]  temp_data,
  output logic [15:0] rpm,
  output logic        pkt_valid,
  output logic        frame_err
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CLKS - 1);
  localparam logic [ToW-1:0] ToOne  = ToW'(1);

  logic [7:0] rx_byte;
  logic       byte_vld, byte_ferr, start, fsm_idle;

  uart_rx_byte #(
    .CLK_FREQ (CLK_FREQ),
    .UART_BPS (UART_BPS)
  ) u_rx_byte (
    .clk_i       (sys_clk),
    .rst_i       (sys_rst),
    .rx_i        (rx),
    .byte_o      (rx_byte),
    .byte_vld_o  (byte_vld),
    .frame_err_o (byte_ferr),
    .start_o     (start),
    .idle_o      (fsm_idle)
  );

  logic [1:0]     idx_q, idx_d;
  logic [7:0]     temp_buf_q, temp_buf_d;
  logic [7:0]     rpm_lo_q, rpm_lo_d;
  logic [ToW-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]     temp_q, temp_d;
  logic [15:0]    rpm_q, rpm_d;
  logic           pkt_valid_q, pkt_valid_d;
  logic           timeout;

  always_comb begin
    idx_d       = idx_q;
    temp_buf_d  = temp_buf_q;
    rpm_lo_d    = rpm_lo_q;
    idle_cnt_d  = idle_cnt_q;
    temp_d      = temp_q;
    rpm_d       = rpm_q;
    pkt_valid_d = 1'b0;

    // Only a partially received packet can time out.
    timeout = fsm_idle && (idx_q != IDX_TEMP) && (idle_cnt_q == ToLast);

    if (start || (idx_q == IDX_TEMP)) begin
      idle_cnt_d = '0;
    end else if (fsm_idle) begin
      idle_cnt_d = timeout ? '0 : idle_cnt_q + ToOne;
    end

    // A start on the expiring cycle still proceeds: the index resets and it becomes byte0.
    if (byte_ferr || timeout) begin
      idx_d = IDX_TEMP;
    end else if (byte_vld) begin
      unique case (idx_q)
        IDX_TEMP: begin
          temp_buf_d = rx_byte;
          idx_d      = IDX_RPM_LO;
        end
        IDX_RPM_LO: begin
          rpm_lo_d = rx_byte;
          idx_d    = IDX_RPM_HI;
        end
        IDX_RPM_HI: begin
          temp_d      = temp_buf_q;
          rpm_d       = {rx_byte, rpm_lo_q};
          pkt_valid_d = 1'b1;
          idx_d       = IDX_TEMP;
        end
        default: idx_d = IDX_TEMP;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      idx_q       <= IDX_TEMP;
      temp_buf_q  <= '0;
      rpm_lo_q    <= '0;
      idle_cnt_q  <= '0;
      temp_q      <= '0;
      rpm_q       <= '0;
      pkt_valid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      temp_buf_q  <= temp_buf_d;
      rpm_lo_q    <= rpm_lo_d;
      idle_cnt_q  <= idle_cnt_d;
      temp_q      <= temp_d;
      rpm_q       <= rpm_d;
      pkt_valid_q <= pkt_valid_d;
    end
  end

  assign temp_data = temp_q;
  assign rpm       = rpm_q;
  assign pkt_valid = pkt_valid_q;
  assign frame_err = byte_ferr;

endmodule

// File: tb/tb_uart_rx_packet.sv
// Bench for uart_rx_packet. The line runs at 50 clocks per bit (50 MHz / 1 Mbaud) with a
// 1000-clock inter-byte timeout so the whole run stays short; the directed cases scale the
// original 115200-baud scenario times by the same ratio. A byte-level model predicts the
// strobe sequence and output values; one process compares the DUT every cycle.
module tb_uart_rx_packet;

  localparam int unsigned ClkFreq = 50_000_000;
  localparam int unsigned Bps     = 1_000_000;
  localparam int unsigned Timeout = 1000;
  localparam int          BitClks = 50;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        rx      = 1'b1;
  logic [7:0]  temp_data;
  logic [15:0] rpm;
  logic        pkt_valid, frame_err;

  always #5 sys_clk = ~sys_clk;

  uart_rx_packet #(
    .UART_BPS     (Bps),
    .CLK_FREQ     (ClkFreq),
    .TIMEOUT_CLKS (Timeout)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .rx        (rx),
    .temp_data (temp_data),
    .rpm       (rpm),
    .pkt_valid (pkt_valid),
    .frame_err (frame_err)
  );

  typedef struct {
    bit          is_err;
    logic [7:0]  t;
    logic [15:0] r;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         cmp_ev;
  int          vectors     = 0;
  int          miscompares = 0;
  int          pv_cnt      = 0;
  int          fe_cnt      = 0;
  logic [7:0]  exp_temp    = 8'h00;
  logic [15:0] exp_rpm     = 16'h0000;

  // Byte-level packet model: which bytes have accumulated toward the next packet.
  int          m_idx = 0;
  logic [7:0]  m_buf [0:2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good, input int idle_clks);
    if (m_idx != 0 && idle_clks >= int'(Timeout)) m_idx = 0;
    if (!good) begin
      exp_q.push_back('{is_err: 1'b1, t: 8'h00, r: 16'h0000});
      m_idx = 0;
    end else begin
      m_buf[m_idx] = b;
      m_idx++;
      if (m_idx == 3) begin
        exp_q.push_back('{is_err: 1'b0, t: m_buf[0], r: {m_buf[2], m_buf[1]}});
        m_idx = 0;
      end
    end
  endtask

  // gap: idle-high clocks before the start bit.
  task automatic send_byte(input logic [7:0] b, input int bit_clks, input bit good,
                           input int gap);
    model_byte(b, good, gap + bit_clks / 2);
    rx = 1'b1;
    repeat (gap) @(negedge sys_clk);
    rx = 1'b0;
    repeat (bit_clks) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bit_clks) @(negedge sys_clk);
    end
    rx = good;
    repeat (bit_clks) @(negedge sys_clk);
    rx = 1'b1;
    // A low stop bit must be followed by some idle high or the next start has no edge.
    if (!good) repeat (bit_clks) @(negedge sys_clk);
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int bit_clks, input int gap);
    send_byte(b0, bit_clks, 1'b1, gap);
    send_byte(b1, bit_clks, 1'b1, 0);
    send_byte(b2, bit_clks, 1'b1, 0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge sys_clk);
    check(name, exp_q.size(), 0);
  endtask

  // Every-cycle comparison against the model.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      exp_temp = 8'h00;
      exp_rpm  = 16'h0000;
      check("rst_temp", temp_data, 8'h00);
      check("rst_rpm", rpm, 16'h0000);
      check("rst_strobes", {pkt_valid, frame_err}, 2'b00);
    end else begin
      if (pkt_valid) pv_cnt++;
      if (frame_err) fe_cnt++;
      if (pkt_valid && frame_err) check("strobe_overlap", 1, 0);
      if (pkt_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {pkt_valid, frame_err}, 2'b00);
        end else begin
          cmp_ev = exp_q.pop_front();
          check("strobe_kind", {pkt_valid, frame_err}, cmp_ev.is_err ? 2'b01 : 2'b10);
          if (!cmp_ev.is_err && pkt_valid) begin
            exp_temp = cmp_ev.t;
            exp_rpm  = cmp_ev.r;
          end
        end
      end
      check("temp_data", temp_data, exp_temp);
      check("rpm", rpm, exp_rpm);
    end
  end

  initial begin
    #(10 * 95000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int pv0, fe0;
    logic [7:0] rb;
    int bc, gap;
    bit good;

    repeat (5) @(negedge sys_clk);
    #2 sys_rst = 1'b0;
    repeat (20) @(negedge sys_clk);

    // 1: basic packet
    pv0 = pv_cnt;
    send_pkt(8'h1E, 8'h34, 8'h12, BitClks, 10);
    drain("t1_drain");
    check("t1_temp", temp_data, 8'h1E);
    check("t1_rpm", rpm, 16'h1234);
    check("t1_pv_count", pv_cnt - pv0, 1);

    // 2: byte2 stop bit low, then a clean packet
    pv0 = pv_cnt;
    fe0 = fe_cnt;
    send_byte(8'hAB, BitClks, 1'b1, 10);
    send_byte(8'hCD, BitClks, 1'b1, 0);
    send_byte(8'hEF, BitClks, 1'b0, 0);
    drain("t2_drain_err");
    check("t2_fe_count", fe_cnt - fe0, 1);
    check("t2_pv_count", pv_cnt - pv0, 0);
    check("t2_temp_kept", temp_data, 8'h1E);
    check("t2_rpm_kept", rpm, 16'h1234);
    send_pkt(8'h20, 8'hE8, 8'h03, BitClks, 10);
    drain("t2_drain");
    check("t2_temp", temp_data, 8'h20);
    check("t2_rpm", rpm, 16'h03E8);

    // 3: stray byte, idle past the timeout, then a full packet
    send_byte(8'h55, BitClks, 1'b1, 10);
    send_pkt(8'h28, 8'h10, 8'h27, BitClks, 1040);
    drain("t3_drain");
    check("t3_temp", temp_data, 8'h28);
    check("t3_rpm", rpm, 16'h2710);

    // 4: short low glitch is a false start
    pv0 = pv_cnt;
    fe0 = fe_cnt;
    rx = 1'b0;
    repeat (23) @(negedge sys_clk);
    rx = 1'b1;
    repeat (200) @(negedge sys_clk);
    check("t4_no_pv", pv_cnt - pv0, 0);
    check("t4_no_fe", fe_cnt - fe0, 0);
    send_pkt(8'h11, 8'h22, 8'h33, BitClks, 10);
    drain("t4_drain");
    check("t4_temp", temp_data, 8'h11);
    check("t4_rpm", rpm, 16'h3322);

    // 5: reset during byte1 data bits
    send_byte(8'h77, BitClks, 1'b1, 10);
    rx = 1'b0;
    repeat (BitClks) @(negedge sys_clk);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      repeat (BitClks) @(negedge sys_clk);
    end
    #2 sys_rst = 1'b1;
    exp_q.delete();
    m_idx = 0;
    #1;
    check("t5_rst_temp", temp_data, 8'h00);
    check("t5_rst_rpm", rpm, 16'h0000);
    rx = 1'b1;
    repeat (5) @(negedge sys_clk);
    #2 sys_rst = 1'b0;
    repeat (100) @(negedge sys_clk);
    send_pkt(8'h19, 8'hB8, 8'h0B, BitClks, 10);
    drain("t5_drain");
    check("t5_temp", temp_data, 8'h19);
    check("t5_rpm", rpm, 16'h0BB8);

    // 6: back-to-back packets, sender 2% slow then 2% fast
    pv0 = pv_cnt;
    send_pkt(8'h40, 8'h34, 8'h12, BitClks + 1, 10);
    send_pkt(8'h41, 8'h78, 8'h56, BitClks - 1, 0);
    drain("t6_drain");
    check("t6_pv_count", pv_cnt - pv0, 2);
    check("t6_temp", temp_data, 8'h41);
    check("t6_rpm", rpm, 16'h5678);

    // Random bytes, skew, stop-bit errors and occasional timeouts
    for (int p = 0; p < 36; p++) begin
      rb   = 8'($urandom);
      bc   = int'($urandom_range(BitClks - 1, BitClks + 1));
      good = ($urandom_range(0, 9) != 0);
      gap  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1100, 1500))
                                         : int'($urandom_range(0, 400));
      send_byte(rb, bc, good, gap);
    end
    drain("rand_drain");

    repeat (50) @(negedge sys_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
